// File: rtl/fabric_config_loader.sv
// fabric_config_loader: decodes a packetized config stream into target writes with XOR-checksum commit
module fabric_config_loader #(
  parameter int DATA_W      = 33,
  parameter int ADDR_W      = 8,
  parameter int NUM_TARGETS = 48,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_done,
  output logic              cfg_loaded,
  output logic              cfg_err
);
  localparam logic [1:0] IDLE = 2'd0, SDATA = 2'd1, BDATA = 2'd2, BDATA_WR = 2'd3;
  localparam int AW = ADDR_W + CNT_W;
  logic [1:0]        state;
  logic              armed;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt, idx;
  logic [DATA_W-1:0] word, wd;
  logic [15:0]       chk;
  logic [1:0]        op;
  logic [AW-1:0]     tgt;
  logic              xfer, wr, last, in_range;
  assign s_ready  = armed && state != BDATA_WR;
  assign xfer     = s_valid && s_ready;
  assign op       = s_data[DATA_W-1 -: 2];
  // wide target address so an overrun past NUM_TARGETS never wraps back into range
  assign tgt      = AW'(base) + AW'(idx);
  assign in_range = tgt < AW'(NUM_TARGETS);
  assign last     = idx == cnt - 1'b1;
  assign wr       = (state == SDATA && xfer) || state == BDATA_WR;
  assign wd       = state == BDATA_WR ? word : s_data;
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      state      <= IDLE;
      armed      <= 1'b0;
      base       <= '0;
      cnt        <= '0;
      idx        <= '0;
      word       <= '0;
      chk        <= '0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      cfg_done   <= 1'b0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      armed    <= 1'b1;
      cfg_we   <= 1'b0;
      cfg_done <= 1'b0;
      if (wr) begin
        cfg_we    <= in_range;
        cfg_addr  <= tgt[ADDR_W-1:0];
        cfg_wdata <= wd;
        if (!in_range) cfg_err <= 1'b1;
        idx <= idx + 1'b1;
        if (last) state <= IDLE;
      end
      if (xfer && state != IDLE) chk <= chk ^ s_data[15:0];
      if (xfer && state == BDATA) begin
        word  <= s_data;
        idx   <= '0;
        state <= BDATA_WR;
      end
      if (xfer && state == IDLE) begin
        base <= s_data[ADDR_W+15:16];
        cnt  <= s_data[CNT_W-1:0];
        idx  <= '0;
        if (op == 2'b10) begin
          if (chk == s_data[15:0] && !cfg_err) begin
            cfg_done   <= 1'b1;
            cfg_loaded <= 1'b1;
          end else cfg_err <= 1'b1;
          chk <= '0;
        end else if (op == 2'b11) cfg_err <= 1'b1;
        else if (s_data[CNT_W-1:0] != '0) state <= op[0] ? BDATA : SDATA;
      end
    end
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: directed stream packets with a write/commit scoreboard checked by a monitor
module tb_fabric_config_loader;
  logic        clock, clear;
  logic [32:0] s_data;
  logic        s_valid, s_ready, cfg_we, cfg_done, cfg_loaded, cfg_err;
  logic [7:0]  cfg_addr;
  logic [32:0] cfg_wdata;
  typedef struct { logic [7:0] a; logic [32:0] d; int c; } wr_t;
  wr_t exp_wr[$];
  int  exp_done[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  fabric_config_loader dut (
    .clock(clock), .clear(clear), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_done(cfg_done), .cfg_loaded(cfg_loaded), .cfg_err(cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [32:0] hdr(input int op, input int b, input int c);
    logic [1:0]  o = 2'(op);
    logic [7:0]  bb = 8'(b);
    logic [15:0] cc = 16'(c);
    return {o, 7'd0, bb, cc};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // called at a negedge; expectations are queued before the accepting edge
  task automatic send(input logic [32:0] w, input int nwr, input int a0, input int lat, input bit dn);
    int k = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h never accepted", w);
      s_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nwr; i++) exp_wr.push_back('{a: 8'(a0 + i), d: w, c: cyc + 1 + lat + i});
    if (dn) exp_done.push_back(cyc + 1);
    @(negedge clock);
    s_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 0);
    chk({tag, "_we"}, 64'(cfg_we), 0);
    chk({tag, "_addr"}, 64'(cfg_addr), 0);
    chk({tag, "_wdata"}, 64'(cfg_wdata), 0);
    chk({tag, "_done"}, 64'(cfg_done), 0);
    chk({tag, "_loaded"}, 64'(cfg_loaded), 0);
    chk({tag, "_err"}, 64'(cfg_err), 0);
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (cfg_we) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%0h cyc=%0d expected no write", cfg_addr, cfg_wdata, cyc);
      end else begin
        e = exp_wr.pop_front();
        if (cfg_addr !== e.a || cfg_wdata !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL wr: got addr=%0d data=%0h cyc=%0d expected addr=%0d data=%0h cyc=%0d",
                   cfg_addr, cfg_wdata, cyc, e.a, e.d, e.c);
        end
      end
    end
    if (cfg_done) begin
      n_cmp++;
      if (exp_done.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: got pulse at cyc=%0d expected none", cyc);
      end else if (exp_done[0] != cyc) begin
        n_bad++;
        $display("FAIL done_cycle: got cyc=%0d expected cyc=%0d", cyc, exp_done[0]);
        void'(exp_done.pop_front());
      end else void'(exp_done.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    clear = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    clear = 1'b1;
    #1 chk("ready_after_release", 64'(s_ready), 0);
    @(negedge clock);
    chk("ready_armed", 64'(s_ready), 1);

    send(hdr(0, 4, 3), 0, 0, 0, 0);
    send(33'h1, 1, 4, 0, 0);
    send(33'h2, 1, 5, 0, 0);
    send(33'h3, 1, 6, 0, 0);
    send(hdr(2, 0, 16'h0000), 0, 0, 0, 1);
    chk("t1_loaded", 64'(cfg_loaded), 1);
    chk("t1_err", 64'(cfg_err), 0);

    send(hdr(1, 8, 8), 0, 0, 0, 0);
    send(33'h0_0000_ABCD, 8, 8, 1, 0);
    lo = 0;
    while (!s_ready && lo < 20) begin
      lo++;
      @(negedge clock);
    end
    chk("bcast_ready_low_cycles", 64'(lo), 8);
    send(hdr(2, 0, 16'hABCD), 0, 0, 0, 1);
    chk("t2_loaded", 64'(cfg_loaded), 1);

    send(hdr(0, 46, 4), 0, 0, 0, 0);
    send(33'h10, 1, 46, 0, 0);
    send(33'h20, 1, 47, 0, 0);
    send(33'h30, 0, 0, 0, 0);
    send(33'h40, 0, 0, 0, 0);
    chk("range_err", 64'(cfg_err), 1);
    send(hdr(2, 0, 16'h0040), 0, 0, 0, 0);
    chk("range_loaded_kept", 64'(cfg_loaded), 1);
    chk("range_ready", 64'(s_ready), 1);

    pulse_reset();
    chk("rst2_loaded", 64'(cfg_loaded), 0);
    chk("rst2_err", 64'(cfg_err), 0);
    send(hdr(0, 0, 2), 0, 0, 0, 0);
    send(33'h5, 1, 0, 0, 0);
    send(33'h6, 1, 1, 0, 0);
    send(hdr(2, 0, 16'h1234), 0, 0, 0, 0);
    chk("badsum_err", 64'(cfg_err), 1);
    chk("badsum_loaded", 64'(cfg_loaded), 0);

    pulse_reset();
    send(hdr(3, 0, 0), 0, 0, 0, 0);
    chk("reserved_err", 64'(cfg_err), 1);
    chk("reserved_ready", 64'(s_ready), 1);
    chk("reserved_loaded", 64'(cfg_loaded), 0);

    pulse_reset();
    send(hdr(0, 10, 2), 0, 0, 0, 0);
    send(33'h7, 1, 10, 0, 0);
    s_data = 33'h1_FFFF_FFFF;
    repeat (3) @(negedge clock);
    send(33'h9, 1, 11, 0, 0);
    send(hdr(1, 20, 0), 0, 0, 0, 0);
    send(hdr(0, 30, 0), 0, 0, 0, 0);
    send(hdr(0, 12, 1), 0, 0, 0, 0);
    send(33'h4, 1, 12, 0, 0);
    send(hdr(2, 0, 16'h000A), 0, 0, 0, 1);
    chk("t5_loaded", 64'(cfg_loaded), 1);
    chk("t5_err", 64'(cfg_err), 0);

    send(hdr(1, 16, 8), 0, 0, 0, 0);
    send(33'h1234, 8, 16, 1, 0);
    repeat (3) @(negedge clock);
    #2 clear = 1'b0;
    #1 check_zero("midburst");
    exp_wr.delete();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    send(hdr(0, 2, 1), 0, 0, 0, 0);
    send(33'h55, 1, 2, 0, 0);
    send(hdr(2, 0, 16'h0055), 0, 0, 0, 1);
    chk("t6_loaded", 64'(cfg_loaded), 1);

    repeat (3) @(negedge clock);
    chk("wr_queue_drained", 64'(exp_wr.size()), 0);
    chk("done_queue_drained", 64'(exp_done.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
